// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter slice.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam int REQ_LOADER = 0;
  localparam int REQ_DATA   = 1;
  localparam int REQ_FETCH  = 2;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter; slave is the arbiter's view.
interface mem_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 8,
  parameter int DW    = 8
) ();

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_we;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                mem_en;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;
  logic                busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int PW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    idx,
  output logic             any_req
);

  always_comb begin
    int j;
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any_req && req[j]) begin
        any_req  = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory; one transaction in flight,
// fixed read latency MEM_LAT (>= 1).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          nReset,
  mem_arbiter_if.slave  bus
);

  localparam int PW = idx_w(N_REQ);
  localparam int CW = idx_w(MEM_LAT);

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr;
  logic [N_REQ-1:0] pick_grant;
  logic [PW-1:0]    g;
  logic             any_req;
  logic [N_REQ-1:0] grant_q;
  logic             we_q;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    rdata_q;
  logic             mem_en_r, mem_we_r;
  logic [AW-1:0]    mem_addr_r;
  logic [DW-1:0]    mem_wdata_r;

  rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .grant   (pick_grant),
    .idx     (g),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory strobes are registered so they are clean for exactly the ACCESS cycle.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ptr         <= '0;
      grant_q     <= '0;
      we_q        <= 1'b0;
      cnt         <= '0;
      rdata_q     <= '0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q     <= pick_grant;
            we_q        <= bus.req_we[g];
            ptr         <= (int'(g) == N_REQ - 1) ? '0 : g + PW'(1);
            mem_en_r    <= 1'b1;
            mem_we_r    <= bus.req_we[g];
            mem_addr_r  <= bus.req_addr[int'(g)*AW +: AW];
            mem_wdata_r <= bus.req_wdata[int'(g)*DW +: DW];
          end
        end
        ACCESS: cnt <= CW'(MEM_LAT - 1);
        WAIT: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           rdata_q <= we_q ? '0 : bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Acceptance is suppressed while reset is held so every output reads 0.
  assign bus.req_ready = (state == IDLE && nReset) ? pick_grant : '0;
  assign bus.rsp_valid = (state == RESP) ? grant_q : '0;
  assign bus.rsp_rdata = (state == RESP) ? rdata_q : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic nReset;
  int   n_tests;
  int   n_fail;

  mem_arbiter_if #(.N_REQ(3), .AW(8), .DW(8)) if1 ();
  mem_arbiter_if #(.N_REQ(3), .AW(8), .DW(8)) if3 ();

  mem_arbiter #(.N_REQ(3), .AW(8), .DW(8), .MEM_LAT(1)) u_dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (if1.slave)
  );

  mem_arbiter #(.N_REQ(3), .AW(8), .DW(8), .MEM_LAT(3)) u_lat3 (
    .clk    (clk),
    .nReset (nReset),
    .bus    (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: read data appears exactly MEM_LAT cycles after mem_en, else 0.
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic       pre_en;
  logic [7:0] pre_addr, pre_data;
  logic [7:0] rd1, rd3a, rd3b, rd3c;

  always @(posedge clk) begin
    if (pre_en) mem1[pre_addr] <= pre_data;
    if (if1.mem_en && if1.mem_we) mem1[if1.mem_addr] <= if1.mem_wdata;
    rd1 <= (if1.mem_en && !if1.mem_we) ? mem1[if1.mem_addr] : 8'h00;
  end

  always @(posedge clk) begin
    if (if3.mem_en && if3.mem_we) mem3[if3.mem_addr] <= if3.mem_wdata;
    rd3a <= (if3.mem_en && !if3.mem_we) ? mem3[if3.mem_addr] : 8'h00;
    rd3b <= rd3a;
    rd3c <= rd3b;
  end

  assign if1.mem_rdata = rd1;
  assign if3.mem_rdata = rd3c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the MEM_LAT=1 instance; starts and ends at an IDLE cycle.
  task automatic txn1(input int r, input logic we, input logic [7:0] addr, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input string tag);
    if1.req_valid       = 3'b001 << r;
    if1.req_we          = we ? (3'b001 << r) : 3'b000;
    if1.req_addr[r*8 +: 8]  = addr;
    if1.req_wdata[r*8 +: 8] = wd;
    #1 chk({tag, "_ready"}, 32'(if1.req_ready), 32'(3'b001 << r));
    cyc();
    if1.req_valid = '0;
    #1;
    chk({tag, "_mem_en"}, 32'(if1.mem_en), 1);
    chk({tag, "_mem_we"}, 32'(if1.mem_we), 32'(we));
    chk({tag, "_mem_addr"}, 32'(if1.mem_addr), 32'(addr));
    if (we) chk({tag, "_mem_wdata"}, 32'(if1.mem_wdata), 32'(wd));
    cyc();
    #1;
    chk({tag, "_wait_en"}, 32'(if1.mem_en), 0);
    chk({tag, "_wait_rsp"}, 32'(if1.rsp_valid), 0);
    cyc();
    #1;
    chk({tag, "_rsp"}, 32'(if1.rsp_valid), 32'(3'b001 << r));
    chk({tag, "_rdata"}, 32'(if1.rsp_rdata), 32'(exp_rd));
    cyc();
    #1;
    chk({tag, "_done_rsp"}, 32'(if1.rsp_valid), 0);
    chk({tag, "_done_rdata"}, 32'(if1.rsp_rdata), 0);
    chk({tag, "_done_busy"}, 32'(if1.busy), 0);
  endtask

  // Requester 0 transaction on the MEM_LAT=3 instance.
  task automatic txn3(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input string tag);
    int nb = 0;
    if3.req_valid      = 3'b001;
    if3.req_we         = {2'b00, we};
    if3.req_addr[7:0]  = addr;
    if3.req_wdata[7:0] = wd;
    #1 chk({tag, "_ready"}, 32'(if3.req_ready), 1);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c == 1) if3.req_valid = '0;
      #1;
      if (if3.busy) nb++;
      if (c == 1) chk({tag, "_mem_en"}, 32'(if3.mem_en), 1);
      else if (c < 5) chk({tag, "_early_rsp"}, 32'(if3.rsp_valid) | 32'(if3.mem_en), 0);
      else if (c == 5) begin
        chk({tag, "_rsp"}, 32'(if3.rsp_valid), 1);
        chk({tag, "_rdata"}, 32'(if3.rsp_rdata), 32'(exp_rd));
      end
    end
    chk({tag, "_busy_cycles"}, 32'(nb), 5);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nReset  = 1'b0;
    pre_en  = 1'b0;
    pre_addr = 8'h00;
    pre_data = 8'h00;
    if1.req_valid = '0; if1.req_we = '0; if1.req_addr = '0; if1.req_wdata = '0;
    if3.req_valid = '0; if3.req_we = '0; if3.req_addr = '0; if3.req_wdata = '0;

    // Reset state, with requests asserted to show acceptance is blocked.
    cyc();
    pre_en = 1'b1; pre_addr = 8'h10; pre_data = 8'hA5;
    if1.req_valid = 3'b111;
    #1;
    chk("rst_ready", 32'(if1.req_ready), 0);
    chk("rst_busy", 32'(if1.busy), 0);
    chk("rst_mem_en", 32'(if1.mem_en), 0);
    chk("rst_rsp", 32'(if1.rsp_valid), 0);
    cyc();
    pre_en = 1'b0;
    if1.req_valid = '0;
    nReset = 1'b1;

    txn1(REQ_FETCH, 1'b0, 8'h10, 8'h00, 8'hA5, "rd_fetch");
    txn1(REQ_DATA, 1'b1, 8'h20, 8'h3C, 8'h00, "wr_data");
    txn1(REQ_DATA, 1'b0, 8'h20, 8'h00, 8'h3C, "rd_data");

    // Round-robin with all requesters held high from reset.
    nReset = 1'b0;
    if1.req_valid = 3'b111;
    if1.req_we    = 3'b000;
    if1.req_addr  = {8'h10, 8'h02, 8'h01};
    cyc();
    nReset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_grant", 32'(if1.req_ready), 32'(3'b001 << (k % 3)));
      for (int j = 1; j <= 3; j++) begin
        cyc();
        #1 chk("rr_gap_ready", 32'(if1.req_ready), 0);
        if (j == 3) chk("rr_rsp", 32'(if1.rsp_valid), 32'(3'b001 << (k % 3)));
      end
      cyc();
    end
    if1.req_valid = '0;

    // Late requester 0 arrives during requester 2's WAIT; ptr = 0 must favour it.
    if1.req_valid = 3'b100;
    #1 chk("late_first", 32'(if1.req_ready), 32'(3'b100));
    cyc();
    if1.req_valid = '0;
    cyc();
    if1.req_valid = 3'b101;
    #1 chk("late_wait_ready", 32'(if1.req_ready), 0);
    cyc();
    #1;
    chk("late_resp_ready", 32'(if1.req_ready), 0);
    chk("late_resp_rsp", 32'(if1.rsp_valid), 32'(3'b100));
    chk("late_resp_rdata", 32'(if1.rsp_rdata), 32'h A5);
    cyc();
    #1 chk("late_grant0", 32'(if1.req_ready), 32'(3'b001));
    cyc();
    if1.req_valid = '0;
    cyc();
    cyc();
    #1 chk("late_rsp0", 32'(if1.rsp_valid), 32'(3'b001));
    cyc();

    // Reset during WAIT aborts; ptr (1 after granting 0) returns to 0.
    if1.req_valid = 3'b001;
    #1 chk("abort_ready", 32'(if1.req_ready), 32'(3'b001));
    cyc();
    if1.req_valid = '0;
    cyc();
    #1 chk("abort_busy_pre", 32'(if1.busy), 1);
    if1.req_valid = 3'b011;
    nReset = 1'b0;
    #1;
    chk("abort_busy", 32'(if1.busy), 0);
    chk("abort_outs", 32'(if1.rsp_valid) | 32'(if1.req_ready) | 32'(if1.mem_en) | 32'(if1.rsp_rdata), 0);
    cyc();
    #1 chk("abort_no_rsp", 32'(if1.rsp_valid), 0);
    cyc();
    nReset = 1'b1;
    #1 chk("abort_ptr0", 32'(if1.req_ready), 32'(3'b001));
    cyc();
    if1.req_valid = '0;
    cyc();
    cyc();
    #1 chk("abort_next_rsp", 32'(if1.rsp_valid), 32'(3'b001));
    cyc();

    // Latency sweep on the MEM_LAT=3 instance.
    txn3(1'b1, 8'h40, 8'h5A, 8'h00, "lat3_wr");
    txn3(1'b0, 8'h40, 8'h00, 8'h5A, "lat3_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the processor's single-port memory among N_REQ requesters: program loader, load/store unit and instruction fetch.
- Round-robin arbitration; one transaction outstanding at a time; fixed memory read latency.
- Instantiated inside top between the requesters and the memory; the memory itself is outside this block.

Parameters:
- N_REQ, 3, number of requesters. Index 0 = loader, 1 = data, 2 = fetch.
- AW, 8, address width.
- DW, 8, data width.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata. Must be >= 1; 0 is unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request.
- req_we  in  N_REQ  per-requester write enable.
- req_addr  in  N_REQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
- req_wdata  in  N_REQ*DW  packed write data, same packing as req_addr.
- req_ready  out  N_REQ  one-hot acceptance.
- rsp_valid  out  N_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DW  shared read data, valid only with rsp_valid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer ptr = 0; captured registers cleared.
- Reset mid-transaction aborts it. No rsp_valid is issued for the aborted transaction.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any req_valid is set, the winner g is the first set bit scanning ptr, ptr+1, ... with wrap modulo N_REQ.
  - req_ready[g] = 1 combinationally in the same cycle. Only one bit is ever set.
  - On that edge, capture req_we[g], req_addr[g] and req_wdata[g]. Set ptr = (g+1) mod N_REQ. Go to ACCESS.
  - No request: stay in IDLE; req_ready = 0.
- ACCESS (exactly 1 cycle):
  - mem_en = 1 with the captured mem_we, mem_addr and mem_wdata.
  - Load the latency counter with MEM_LAT-1 and go to WAIT.
  - mem_en, mem_we, mem_addr and mem_wdata are registered outputs. They are 0 outside ACCESS.
- WAIT:
  - Decrement the counter each cycle; go to RESP the cycle after it reaches 0.
  - With MEM_LAT = 1, WAIT lasts exactly 1 cycle.
- RESP (exactly 1 cycle):
  - rsp_valid[g] = 1.
  - Read: rsp_rdata = mem_rdata, sampled at the end of the last WAIT cycle.
  - Write: rsp_rdata = 0.
  - Return to IDLE.
- Timing: accept at cycle T, mem_en at T+1, rsp_valid at T+2+MEM_LAT, next accept possible at T+3+MEM_LAT.
- Handshake rules:
  - A requester holds req_valid, req_we, req_addr and req_wdata stable until req_ready.
  - Dropping req_valid before req_ready is legal; that request is simply not accepted.
  - Requests arriving outside IDLE wait; req_ready stays 0.
- Fairness: a requester that keeps req_valid high is granted within N_REQ grants.
- Simultaneous requests resolve by ptr only, with no static priority.
- rsp_rdata holds 0 whenever rsp_valid = 0.

Decomposition:
- Package mem_arb_pkg contains:
  - state_t enum {IDLE, ACCESS, WAIT, RESP};
  - localparam REQ_LOADER = 0, REQ_DATA = 1, REQ_FETCH = 2.
- Sub-module rr_picker (combinational):
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and binary index g, plus any_req.
- mem_arbiter holds the FSM, the capture registers, the latency counter and ptr.

Test Plan:
- Single read: memory preloaded with [0x10] = 0xA5. req_valid[2] = 1, addr 0x10. Expected: req_ready = 3'b100 that cycle, mem_en one cycle later, rsp_valid = 3'b100 with rsp_rdata = 0xA5 two cycles after mem_en. Test runs with MEM_LAT = 1.
- Write then read: requester 1 writes 0x3C to 0x20, then reads 0x20. Expected: write rsp_valid[1] with rsp_rdata = 0x00; the read returns 0x3C.
- Round-robin: all three req_valid held high from reset. Expected grant order 0, 1, 2, 0, 1, 2, with grants 4 cycles apart.
- Late requester: requester 0 raises req_valid during requester 2's WAIT. Expected: req_ready stays 0 until IDLE, then requester 0 is granted (ptr = 0 after the grant to 2).
- Reset mid-operation: pull nReset low during WAIT. Expected: all outputs 0 immediately, no rsp_valid afterwards, and ptr = 0 after release.
- Latency sweep at MEM_LAT = 3. Expected: rsp_valid 4 cycles after mem_en, and busy high for exactly 5 cycles per transaction.
